// File: rtl/psk_pkg.sv
// Shared PSK definitions: NCO/LUT/sample widths, transmitter FSM states and the sine table.
// The Costas-loop receiver imports the same package so both ends agree on the waveform.
package psk_pkg;

    localparam int unsigned NcoWidth     = 32;
    localparam int unsigned LutAddrWidth = 8;
    localparam int unsigned SampleWidth  = 8;
    localparam int unsigned SymCntWidth  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData
    } psk_state_e;

    // round-half-away(127 * sin(2*pi*k/256)) for k = 0..64 (first quarter wave)
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] q;
        case (k)
            7'd0:  q = 7'd0;
            7'd1:  q = 7'd3;
            7'd2:  q = 7'd6;
            7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;
            7'd5:  q = 7'd16;
            7'd6:  q = 7'd19;
            7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;
            7'd9:  q = 7'd28;
            7'd10: q = 7'd31;
            7'd11: q = 7'd34;
            7'd12: q = 7'd37;
            7'd13: q = 7'd40;
            7'd14: q = 7'd43;
            7'd15: q = 7'd46;
            7'd16: q = 7'd49;
            7'd17: q = 7'd51;
            7'd18: q = 7'd54;
            7'd19: q = 7'd57;
            7'd20: q = 7'd60;
            7'd21: q = 7'd63;
            7'd22: q = 7'd65;
            7'd23: q = 7'd68;
            7'd24: q = 7'd71;
            7'd25: q = 7'd73;
            7'd26: q = 7'd76;
            7'd27: q = 7'd78;
            7'd28: q = 7'd81;
            7'd29: q = 7'd83;
            7'd30: q = 7'd85;
            7'd31: q = 7'd88;
            7'd32: q = 7'd90;
            7'd33: q = 7'd92;
            7'd34: q = 7'd94;
            7'd35: q = 7'd96;
            7'd36: q = 7'd98;
            7'd37: q = 7'd100;
            7'd38: q = 7'd102;
            7'd39: q = 7'd104;
            7'd40: q = 7'd106;
            7'd41: q = 7'd107;
            7'd42: q = 7'd109;
            7'd43: q = 7'd111;
            7'd44: q = 7'd112;
            7'd45: q = 7'd113;
            7'd46: q = 7'd115;
            7'd47: q = 7'd116;
            7'd48: q = 7'd117;
            7'd49: q = 7'd118;
            7'd50: q = 7'd120;
            7'd51: q = 7'd121;
            7'd52: q = 7'd122;
            7'd53: q = 7'd122;
            7'd54: q = 7'd123;
            7'd55: q = 7'd124;
            7'd56: q = 7'd125;
            7'd57: q = 7'd125;
            7'd58: q = 7'd126;
            7'd59: q = 7'd126;
            7'd60: q = 7'd126;
            7'd61: q = 7'd127;
            7'd62: q = 7'd127;
            7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Full 256-entry sine built from quarter-wave symmetry, so LUT[k+128] == -LUT[k] exactly.
    function automatic logic signed [SampleWidth-1:0] sine_lut(input logic [LutAddrWidth-1:0] idx);
        logic [6:0]                    off;
        logic signed [SampleWidth-1:0] mag;
        off = idx[6] ? 7'(7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag = $signed({1'b0, quarter_sine(off)});
        return idx[7] ? -mag : mag;
    endfunction

endpackage

// File: rtl/psk_nco_lut.sv
// Free-running phase accumulator feeding a registered sine lookup with a pi phase-flip input.
// blank_i forces the registered sample to zero without disturbing carrier phase continuity.
module psk_nco_lut
    import psk_pkg::*;
#(
    parameter logic [NcoWidth-1:0] PHASE_INC = 32'd171_798_692
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          phase_flip_i,
    input  logic                          blank_i,
    output logic signed [SampleWidth-1:0] sample_o
);

    logic [NcoWidth-1:0]           phase_q, phase_d;
    logic signed [SampleWidth-1:0] sample_q, sample_d;
    logic [LutAddrWidth-1:0]       lut_idx;

    always_comb begin
        phase_d  = phase_q + PHASE_INC;
        lut_idx  = phase_q[NcoWidth-1 -: LutAddrWidth]
                 ^ {phase_flip_i, {(LutAddrWidth-1){1'b0}}};
        sample_d = blank_i ? '0 : sine_lut(lut_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            sample_q <= '0;
        end else begin
            phase_q  <= phase_d;
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK burst transmitter: unmodulated preamble, then one buffered data bit per symbol
// selecting carrier phase 0 or pi (optionally differentially encoded).
module bpsk_modulator
    import psk_pkg::*;
#(
    parameter logic [NcoWidth-1:0] PHASE_INC    = 32'd171_798_692,
    parameter int unsigned         SYMBOL_LEN   = 64,
    parameter int unsigned         PREAMBLE_LEN = 8,
    parameter bit                  DIFF_EN      = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    output logic signed [SampleWidth-1:0] psk_out,
    output logic                          sym_strobe,
    output logic                          busy,
    output logic                          underrun
);

    localparam logic [SymCntWidth-1:0] SymLast = SymCntWidth'(SYMBOL_LEN - 1);
    localparam logic [SymCntWidth-1:0] PreLast =
        (PREAMBLE_LEN == 0) ? '0 : SymCntWidth'(PREAMBLE_LEN - 1);
    localparam psk_state_e StFirst = (PREAMBLE_LEN == 0) ? StData : StPreamble;

    psk_state_e             state_q, state_d;
    logic [SymCntWidth-1:0] cnt_q, cnt_d;
    logic [SymCntWidth-1:0] pre_cnt_q, pre_cnt_d;
    logic                   sym_phase_q, sym_phase_d;
    logic                   buf_full_q, buf_full_d;
    logic                   buf_bit_q, buf_bit_d;
    logic                   strobe;
    logic                   data_edge;
    logic                   underrun_int;

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        sym_phase_d  = sym_phase_q;
        buf_full_d   = buf_full_q;
        buf_bit_d    = buf_bit_q;
        underrun_int = 1'b0;

        strobe    = (state_q != StIdle) && (cnt_q == SymLast);
        // The last preamble boundary follows the same rule as a data boundary.
        data_edge = strobe && ((state_q == StData) ||
                               ((state_q == StPreamble) && (pre_cnt_q == PreLast)));

        cnt_d = ((state_q == StIdle) || strobe) ? '0 : cnt_q + 1'b1;

        if (bit_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_bit_d  = bit_in;
        end

        unique case (state_q)
            StIdle: begin
                sym_phase_d = 1'b0;
                pre_cnt_d   = '0;
                if (tx_en) begin
                    state_d = StFirst;
                end
            end
            StPreamble: begin
                if (strobe && !data_edge) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (data_edge) begin
            if (buf_full_q) begin
                buf_full_d  = 1'b0;
                sym_phase_d = DIFF_EN ? (sym_phase_q ^ buf_bit_q) : buf_bit_q;
                state_d     = StData;
            end else if (!tx_en) begin
                sym_phase_d = 1'b0;
                state_d     = StIdle;
            end else begin
                // Filler symbol carries bit 0.
                underrun_int = 1'b1;
                sym_phase_d  = DIFF_EN ? sym_phase_q : 1'b0;
                state_d      = StData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pre_cnt_q   <= '0;
            sym_phase_q <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            sym_phase_q <= sym_phase_d;
            buf_full_q  <= buf_full_d;
            buf_bit_q   <= buf_bit_d;
        end
    end

    psk_nco_lut #(
        .PHASE_INC (PHASE_INC)
    ) u_nco_lut (
        .clk          (clk),
        .rst          (rst),
        .phase_flip_i (sym_phase_q),
        .blank_i      (state_q == StIdle),
        .sample_o     (psk_out)
    );

    assign bit_ready  = !buf_full_q;
    assign sym_strobe = strobe;
    assign busy       = (state_q != StIdle);
    assign underrun   = underrun_int;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench for bpsk_modulator: two instances (plain and differential) share stimulus;
// expected samples come from a real-valued sine reference and hand-written symbol phases.
module tb_bpsk_modulator;

    localparam logic [31:0] PhaseInc = 32'h0400_0000;
    localparam int unsigned SymLen   = 16;
    localparam int unsigned PreLen   = 2;

    logic clk = 1'b0;
    logic rst, tx_en, bit_in, bit_valid;
    logic bit_ready, sym_strobe, busy, underrun;
    logic signed [7:0] psk_out;
    logic d_bit_ready, d_sym_strobe, d_busy, d_underrun;
    logic signed [7:0] d_psk_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bpsk_modulator #(
        .PHASE_INC    (PhaseInc),
        .SYMBOL_LEN   (SymLen),
        .PREAMBLE_LEN (PreLen),
        .DIFF_EN      (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .psk_out    (psk_out),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .underrun   (underrun)
    );

    bpsk_modulator #(
        .PHASE_INC    (PhaseInc),
        .SYMBOL_LEN   (SymLen),
        .PREAMBLE_LEN (PreLen),
        .DIFF_EN      (1'b1)
    ) dut_diff (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (d_bit_ready),
        .psk_out    (d_psk_out),
        .sym_strobe (d_sym_strobe),
        .busy       (d_busy),
        .underrun   (d_underrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_lut(input int k);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle right after the last reset edge (NCO index 0), with tx_en raised in it.
    // Symbol s occupies cycles 16s+1..16s+16; ph_* give each symbol's phase, umask its underrun.
    task automatic run_burst(input string name, input bit do_reset, input int nbits,
                             input logic [7:0] bits, input int drop_cycle, input int idle_cycle,
                             input int last_k, input logic [7:0] ph_a, input logic [7:0] ph_b,
                             input logic [7:0] umask);
        int idx;
        bit xfer;
        int c, s, ea, eb;
        bit e_busy, e_strobe, e_under;
        if (do_reset) begin
            rst = 1'b1; tx_en = 1'b0; bit_valid = 1'b0;
            tick();
            tick();
            rst = 1'b0;
        end
        tx_en     = 1'b1;
        idx       = 0;
        bit_valid = (nbits > 0);
        bit_in    = bits[0];
        for (int k = 1; k <= last_k; k++) begin
            xfer = bit_valid && bit_ready;
            tick();
            if (xfer) idx++;
            if (k == drop_cycle) tx_en = 1'b0;
            bit_valid = (idx < nbits);
            bit_in    = bits[idx];

            c      = k - 1;
            e_busy = (k < idle_cycle);
            if (c >= 1 && c < idle_cycle) begin
                s  = (c - 1) / 16;
                ea = ref_lut(((4 * c) % 256) ^ (ph_a[s] ? 128 : 0));
                eb = ref_lut(((4 * c) % 256) ^ (ph_b[s] ? 128 : 0));
            end else begin
                ea = 0;
                eb = 0;
            end
            e_strobe = e_busy && (k % 16 == 0);
            e_under  = e_strobe ? umask[k/16 - 1] : 1'b0;

            check($sformatf("%s psk k=%0d", name, k), int'(psk_out), ea);
            check($sformatf("%s diff_psk k=%0d", name, k), int'(d_psk_out), eb);
            check($sformatf("%s busy k=%0d", name, k), int'(busy), int'(e_busy));
            check($sformatf("%s strobe k=%0d", name, k), int'(sym_strobe), int'(e_strobe));
            check($sformatf("%s underrun k=%0d", name, k), int'(underrun), int'(e_under));
            if (name == "pre" && k == 17) check("preamble peak", int'(psk_out), 127);
        end
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;

        // Reset held, then idle with tx_en low.
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 10) rst = 1'b0;
            check($sformatf("idle psk i=%0d", i), int'(psk_out), 0);
            check($sformatf("idle busy i=%0d", i), int'(busy), 0);
            check($sformatf("idle ready i=%0d", i), int'(bit_ready), 1);
            check($sformatf("idle strobe i=%0d", i), int'(sym_strobe), 0);
            check($sformatf("idle underrun i=%0d", i), int'(underrun), 0);
        end

        // Preamble only, then filler with underrun at every data boundary.
        run_burst("pre", 1'b1, 0, 8'h00, 0, 1000, 65, 8'h00, 8'h00, 8'b0000_1110);

        // Bits 1,0,1: plain gives pi,0,pi; differential gives pi,pi,0. tx_en drops in symbol 4.
        run_burst("b101", 1'b1, 3, 8'b0000_0101, 70, 81, 90,
                  8'b0001_0100, 8'b0000_1100, 8'h00);

        // Bits 1,1,0: plain gives pi,pi,0; differential gives pi,0,0.
        run_burst("b110", 1'b1, 3, 8'b0000_0011, 70, 81, 90,
                  8'b0000_1100, 8'b0000_0100, 8'h00);

        // One bit, tx_en dropped mid-symbol: symbol completes, no underrun, then idle.
        run_burst("drop", 1'b1, 1, 8'b0000_0001, 40, 49, 56,
                  8'b0000_0100, 8'b0000_0100, 8'h00);

        // Buffer full mid-DATA, then a one-cycle reset.
        run_burst("pre_rst", 1'b1, 2, 8'b0000_0011, 0, 1000, 40,
                  8'b0000_0100, 8'b0000_0100, 8'h00);
        check("rst buf full ready", int'(bit_ready), 0);
        rst = 1'b1; tx_en = 1'b0; bit_valid = 1'b0;
        tick();
        check("rst psk", int'(psk_out), 0);
        check("rst busy", int'(busy), 0);
        check("rst ready", int'(bit_ready), 1);
        check("rst strobe", int'(sym_strobe), 0);
        check("rst underrun", int'(underrun), 0);
        rst = 1'b0;
        run_burst("post_rst", 1'b0, 0, 8'h00, 0, 1000, 20, 8'h00, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
